// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: HSYNC/VSYNC/DISP_EN/PIX_X/PIX_Y plus line/frame start pulses.
// Latency: outputs are registered and show the new (hpos,vpos) in the cycle after each PIX_EN edge; PIX_EN=0 holds every output except the start pulses, which drop to 0.
module vga_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0,
    parameter int X_WIDTH  = 10,
    parameter int Y_WIDTH  = 10
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               PIX_EN,
    output logic               HSYNC,
    output logic               VSYNC,
    output logic               DISP_EN,
    output logic [X_WIDTH-1:0] PIX_X,
    output logic [Y_WIDTH-1:0] PIX_Y,
    output logic               LINE_START,
    output logic               FRAME_START
);

    typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} region_t;

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic SYNC_LVL = (SYNC_POL != 0);

    localparam logic [X_WIDTH-1:0] H_LAST  = X_WIDTH'(H_TOTAL - 1);
    localparam logic [X_WIDTH-1:0] H_ACT_L = X_WIDTH'(H_ACTIVE - 1);
    localparam logic [X_WIDTH-1:0] H_FP_L  = X_WIDTH'(H_FP - 1);
    localparam logic [X_WIDTH-1:0] H_SY_L  = X_WIDTH'(H_SYNC - 1);
    localparam logic [X_WIDTH-1:0] H_BP_L  = X_WIDTH'(H_BP - 1);
    localparam logic [Y_WIDTH-1:0] V_LAST  = Y_WIDTH'(V_TOTAL - 1);
    localparam logic [Y_WIDTH-1:0] V_ACT_L = Y_WIDTH'(V_ACTIVE - 1);
    localparam logic [Y_WIDTH-1:0] V_FP_L  = Y_WIDTH'(V_FP - 1);
    localparam logic [Y_WIDTH-1:0] V_SY_L  = Y_WIDTH'(V_SYNC - 1);
    localparam logic [Y_WIDTH-1:0] V_BP_L  = Y_WIDTH'(V_BP - 1);

    generate
        if (H_TOTAL > (1 << X_WIDTH)) begin : g_bad_x_width
            $error("vga_sync_gen: H_TOTAL does not fit in X_WIDTH");
        end
        if (V_TOTAL > (1 << Y_WIDTH)) begin : g_bad_y_width
            $error("vga_sync_gen: V_TOTAL does not fit in Y_WIDTH");
        end
        if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
            V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_region
            $error("vga_sync_gen: every timing region needs at least one pixel/line");
        end
    endgenerate

    function automatic region_t region_after(input region_t r);
        case (r)
            ACTIVE:  return FRONT;
            FRONT:   return SYNC;
            SYNC:    return BACK;
            default: return ACTIVE;
        endcase
    endfunction

    function automatic logic [X_WIDTH-1:0] h_region_last(input region_t r);
        case (r)
            ACTIVE:  return H_ACT_L;
            FRONT:   return H_FP_L;
            SYNC:    return H_SY_L;
            default: return H_BP_L;
        endcase
    endfunction

    function automatic logic [Y_WIDTH-1:0] v_region_last(input region_t r);
        case (r)
            ACTIVE:  return V_ACT_L;
            FRONT:   return V_FP_L;
            SYNC:    return V_SY_L;
            default: return V_BP_L;
        endcase
    endfunction

    region_t              h_state, h_state_nxt;
    region_t              v_state, v_state_nxt;
    logic [X_WIDTH-1:0]   hpos, hpos_nxt, h_cnt, h_cnt_nxt;
    logic [Y_WIDTH-1:0]   vpos, vpos_nxt, v_cnt, v_cnt_nxt;
    logic                 hwrap, fwrap;
    logic                 hsync_nxt, vsync_nxt, disp_nxt;
    logic [X_WIDTH-1:0]   pix_x_nxt;
    logic [Y_WIDTH-1:0]   pix_y_nxt;

    always_comb begin
        hpos_nxt    = hpos;
        vpos_nxt    = vpos;
        h_cnt_nxt   = h_cnt;
        v_cnt_nxt   = v_cnt;
        h_state_nxt = h_state;
        v_state_nxt = v_state;
        hwrap       = PIX_EN && (hpos == H_LAST);
        fwrap       = hwrap && (vpos == V_LAST);

        if (PIX_EN) begin
            hpos_nxt = hwrap ? '0 : hpos + X_WIDTH'(1);
            if (h_cnt == h_region_last(h_state)) begin
                h_state_nxt = region_after(h_state);
                h_cnt_nxt   = '0;
            end else begin
                h_cnt_nxt = h_cnt + X_WIDTH'(1);
            end
        end

        // The vertical FSM only moves on the edge that ends a line.
        if (hwrap) begin
            vpos_nxt = fwrap ? '0 : vpos + Y_WIDTH'(1);
            if (v_cnt == v_region_last(v_state)) begin
                v_state_nxt = region_after(v_state);
                v_cnt_nxt   = '0;
            end else begin
                v_cnt_nxt = v_cnt + Y_WIDTH'(1);
            end
        end

        hsync_nxt = (h_state_nxt == SYNC) ? SYNC_LVL : ~SYNC_LVL;
        vsync_nxt = (v_state_nxt == SYNC) ? SYNC_LVL : ~SYNC_LVL;
        disp_nxt  = (h_state_nxt == ACTIVE) && (v_state_nxt == ACTIVE);
        pix_x_nxt = disp_nxt ? hpos_nxt : '0;
        pix_y_nxt = disp_nxt ? vpos_nxt : '0;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            hpos        <= H_LAST;
            vpos        <= V_LAST;
            h_cnt       <= H_BP_L;
            v_cnt       <= V_BP_L;
            h_state     <= BACK;
            v_state     <= BACK;
            HSYNC       <= ~SYNC_LVL;
            VSYNC       <= ~SYNC_LVL;
            DISP_EN     <= 1'b0;
            PIX_X       <= '0;
            PIX_Y       <= '0;
            LINE_START  <= 1'b0;
            FRAME_START <= 1'b0;
        end else begin
            hpos        <= hpos_nxt;
            vpos        <= vpos_nxt;
            h_cnt       <= h_cnt_nxt;
            v_cnt       <= v_cnt_nxt;
            h_state     <= h_state_nxt;
            v_state     <= v_state_nxt;
            HSYNC       <= hsync_nxt;
            VSYNC       <= vsync_nxt;
            DISP_EN     <= disp_nxt;
            PIX_X       <= pix_x_nxt;
            PIX_Y       <= pix_y_nxt;
            LINE_START  <= hwrap;
            FRAME_START <= fwrap;
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen on a reduced raster (32 x 20) so whole frames fit in a short run.
module tb_vga_sync_gen;

    localparam int HA = 20, HF = 3, HS = 5, HB = 4, HT = HA + HF + HS + HB;
    localparam int VA = 12, VF = 2, VS = 3, VB = 3, VT = VA + VF + VS + VB;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       PIX_EN;
    logic       HSYNC, VSYNC, DISP_EN, LINE_START, FRAME_START;
    logic [4:0] PIX_X, PIX_Y;

    int cmp_n  = 0;
    int fail_n = 0;

    vga_sync_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(0), .X_WIDTH(5), .Y_WIDTH(5)
    ) dut (
        .CLK(CLK), .RESET(RESET), .PIX_EN(PIX_EN),
        .HSYNC(HSYNC), .VSYNC(VSYNC), .DISP_EN(DISP_EN),
        .PIX_X(PIX_X), .PIX_Y(PIX_Y),
        .LINE_START(LINE_START), .FRAME_START(FRAME_START)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        cmp_n++;
        if (act !== exp) begin
            fail_n++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference raster position: plain counters advanced per the raster rules.
    int m_h, m_v;
    bit m_ls, m_fs;
    bit m_ok = 0;

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            m_h = HT - 1; m_v = VT - 1; m_ls = 0; m_fs = 0; m_ok = 1;
        end else begin
            m_ls = 0; m_fs = 0;
            if (PIX_EN) begin
                if (m_h == HT - 1) begin
                    m_h = 0; m_ls = 1;
                    if (m_v == VT - 1) begin
                        m_v = 0; m_fs = 1;
                    end else begin
                        m_v++;
                    end
                end else begin
                    m_h++;
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (m_ok) begin
            bit disp, hs_on, vs_on;
            disp  = (m_h < HA) && (m_v < VA);
            hs_on = (m_h >= HA + HF) && (m_h < HA + HF + HS);
            vs_on = (m_v >= VA + VF) && (m_v < VA + VF + VS);
            check("DISP_EN", DISP_EN, disp);
            check("HSYNC", HSYNC, !hs_on);
            check("VSYNC", VSYNC, !vs_on);
            check("PIX_X", PIX_X, disp ? m_h : 0);
            check("PIX_Y", PIX_Y, disp ? m_v : 0);
            check("LINE_START", LINE_START, m_ls);
            check("FRAME_START", FRAME_START, m_fs);
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int n_disp, n_hs, n_vs, n_ls, n_fs, fs_k, hs_k, vs_k, max_x, max_y;
        int ls_cyc[$];
        int guard;

        RESET  = 1'b1;
        PIX_EN = 1'b0;
        repeat (3) step();
        RESET = 1'b0;
        repeat (2) step();
        check("idle HSYNC", HSYNC, 1);
        check("idle DISP_EN", DISP_EN, 0);

        // First enabled edge after reset lands on (0,0).
        PIX_EN = 1'b1;
        step();
        PIX_EN = 1'b0;
        check("first PIX_X", PIX_X, 0);
        check("first PIX_Y", PIX_Y, 0);
        check("first DISP_EN", DISP_EN, 1);
        check("first FRAME_START", FRAME_START, 1);
        check("first LINE_START", LINE_START, 1);
        step();
        check("held FRAME_START", FRAME_START, 0);
        check("held DISP_EN", DISP_EN, 1);

        // One full frame with PIX_EN stuck high; visits every position once.
        PIX_EN = 1'b1;
        n_disp = 0; n_hs = 0; n_vs = 0; n_ls = 0; n_fs = 0;
        fs_k = -1; hs_k = -1; vs_k = -1; max_x = 0; max_y = 0;
        for (int k = 1; k <= HT * VT; k++) begin
            step();
            n_disp += DISP_EN;
            n_hs   += !HSYNC;
            n_vs   += !VSYNC;
            n_ls   += LINE_START;
            n_fs   += FRAME_START;
            if (FRAME_START && fs_k < 0) fs_k = k;
            if (!HSYNC && hs_k < 0) hs_k = k;
            if (!VSYNC && vs_k < 0) vs_k = k;
            if (PIX_X > max_x) max_x = PIX_X;
            if (PIX_Y > max_y) max_y = PIX_Y;
        end
        check("frame DISP_EN count", n_disp, 240);
        check("frame HSYNC low count", n_hs, 100);
        check("frame VSYNC low count", n_vs, 96);
        check("frame LINE_START count", n_ls, 20);
        check("frame FRAME_START count", n_fs, 1);
        check("frame period", fs_k, 640);
        check("first HSYNC low edge", hs_k, 23);
        check("first VSYNC low edge", vs_k, 448);
        check("PIX_X peak", max_x, 19);
        check("PIX_Y peak", max_y, 11);

        // Pixel tick one cycle in four.
        for (int cyc = 0; cyc < 300; cyc++) begin
            PIX_EN = (cyc % 4 == 0);
            step();
            if (LINE_START) ls_cyc.push_back(cyc);
        end
        if (ls_cyc.size() >= 2) check("slow line length", ls_cyc[1] - ls_cyc[0], 128);
        else check("slow LINE_START pulses seen", ls_cyc.size(), 2);

        // Reset while HSYNC is asserted.
        PIX_EN = 1'b1;
        guard = 0;
        while (m_h != 25 && guard < 200) begin
            step();
            guard++;
        end
        check("reached hpos 25", m_h, 25);
        check("HSYNC active at hpos 25", HSYNC, 0);
        RESET = 1'b1;
        #1;
        check("async HSYNC release", HSYNC, 1);
        check("async PIX_X clear", PIX_X, 0);
        check("async LINE_START clear", LINE_START, 0);
        repeat (3) step();
        RESET = 1'b0;
        step();
        check("restart PIX_X", PIX_X, 0);
        check("restart FRAME_START", FRAME_START, 1);

        // Random ticks with occasional resets; the negedge checker covers every cycle.
        for (int cyc = 0; cyc < 5000; cyc++) begin
            PIX_EN = ($urandom_range(0, 3) != 0);
            if (!RESET && $urandom_range(0, 999) == 0) RESET = 1'b1;
            else if (RESET && $urandom_range(0, 2) == 0) RESET = 1'b0;
            step();
        end
        RESET = 1'b0;
        PIX_EN = 1'b0;
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
        $finish;
    end

endmodule
